// File: rtl/kernel_cache_read_requestor.sv
// Splits engine read commands into 4KB-safe AXI4 INCR bursts and streams the
// returned beats back in order with per-command done and a sticky error flag.
module kernel_cache_read_requestor #(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 512,
  parameter int BEATS_W         = 16,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic               ap_clk,
  input  logic               areset_n,
  input  logic               cache_setup_signal,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [BEATS_W-1:0] req_beats,
  output logic               arvalid,
  input  logic               arready,
  output logic [ADDR_W-1:0]  araddr,
  output logic [7:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic               arid,
  output logic [3:0]         arcache,
  output logic [2:0]         arprot,
  output logic [3:0]         arqos,
  output logic               arlock,
  input  logic               rvalid,
  output logic               rready,
  input  logic [DATA_W-1:0]  rdata,
  input  logic [1:0]         rresp,
  input  logic               rlast,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_last,
  output logic               done,
  output logic               err
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [BEATS_W:0] MAX_BURST_L = (BEATS_W + 1)'(MAX_BURST);
  localparam logic [OUT_W-1:0] MAX_OUT_L   = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN} state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  cur_addr;
  logic [BEATS_W-1:0] rem;
  logic [BEATS_W-1:0] resp_rem;
  logic [BEATS_W:0]   cur_len;
  logic [BEATS_W:0]   len_calc;
  logic [6:0]         page_left;
  logic [OUT_W-1:0]   outstanding;
  logic               req_hs, ar_hs, r_hs, rlast_hs, can_issue, last_burst;

  assign arsize  = 3'b110;
  assign arburst = 2'b01;
  assign arid    = 1'b0;
  assign arcache = 4'b0011;
  assign arprot  = 3'b000;
  assign arqos   = 4'b0000;
  assign arlock  = 1'b0;

  assign rsp_valid = rvalid;
  assign rsp_data  = rdata;
  assign rready    = rsp_ready;
  assign rsp_last  = rvalid & (resp_rem == BEATS_W'(1));

  assign req_hs     = req_valid & req_ready;
  assign ar_hs      = arvalid & arready;
  assign r_hs       = rvalid & rsp_ready;
  assign rlast_hs   = r_hs & rlast & (outstanding != '0);
  assign can_issue  = !cache_setup_signal && (outstanding < MAX_OUT_L);
  assign last_burst = (rem == cur_len[BEATS_W-1:0]);

  // Burst length: smallest of remaining beats, MAX_BURST and beats left in the 4KB page.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    page_left = 7'd64 - {1'b0, cur_addr[11:6]};
    len_calc  = {1'b0, rem};
    if (len_calc > MAX_BURST_L)
      len_calc = MAX_BURST_L;
    if (len_calc > (BEATS_W + 1)'(page_left))
      len_calc = (BEATS_W + 1)'(page_left);
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req_hs && req_beats != '0) state_next = S_CALC;
      S_CALC:  state_next = S_ISSUE;
      S_ISSUE: if (ar_hs) state_next = last_burst ? S_DRAIN : S_CALC;
      S_DRAIN: if (resp_rem == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) state <= S_IDLE;
    else           state <= state_next;
  end

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      req_ready   <= 1'b0;
      arvalid     <= 1'b0;
      araddr      <= '0;
      arlen       <= '0;
      cur_addr    <= '0;
      cur_len     <= '0;
      rem         <= '0;
      resp_rem    <= '0;
      outstanding <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      req_ready <= (state_next == S_IDLE);
      done      <= 1'b0;

      if (req_hs) begin
        cur_addr <= req_addr & ~ADDR_W'(63);
        rem      <= req_beats;
        if (req_beats == '0) done <= 1'b1;
      end

      if (state == S_CALC) begin
        cur_len <= len_calc;
        araddr  <= cur_addr;
        arlen   <= len_calc[7:0] - 8'd1;
      end

      // Once raised, arvalid and its payload stay put until the slave accepts.
      if (state == S_ISSUE) begin
        if (!arvalid) begin
          arvalid <= can_issue;
        end else if (arready) begin
          arvalid  <= 1'b0;
          cur_addr <= cur_addr + ADDR_W'({cur_len, 6'b0});
          rem      <= rem - cur_len[BEATS_W-1:0];
        end
      end

      if (ar_hs && !rlast_hs)      outstanding <= outstanding + 1'b1;
      else if (!ar_hs && rlast_hs) outstanding <= outstanding - 1'b1;

      if (req_hs) begin
        resp_rem <= req_beats;
      end else if (r_hs && resp_rem != '0) begin
        resp_rem <= resp_rem - 1'b1;
        if (resp_rem == BEATS_W'(1)) done <= 1'b1;
      end

      if (r_hs && rresp != 2'b00) err <= 1'b1;
    end
  end

endmodule
